// File: rtl/hazard_unit.sv
// hazard_unit
// Pipeline hazard resolver for the 5-stage MIPS core. It keeps a shadow copy
// of the destination-register and hazard information for the EX, MEM and WB
// stages. From that copy it produces the ID/IF stall and the forwarding
// selects for the ID-stage comparator and the EX-stage ALU operands. It also
// keeps a saturating count of hazard stall cycles.
//
// Ports:
//   clock        in   1   system clock, rising edge
//   reset        in   1   synchronous, active-high
//   DP_Hazards   in   8   {WantRsID, NeedRsID, WantRtID, NeedRtID,
//                          WantRsEX, NeedRsEX, WantRtEX, NeedRtEX}
//   ID_Rs/ID_Rt  in   5   source registers of the instruction in ID
//   ID_WriteReg  in   5   destination register of the instruction in ID
//   ID_RegWrite  in   1   instruction in ID writes the register file
//   ID_MemRead   in   1   instruction in ID is a load
//   Mem_Stall    in   1   external memory stall, freezes the pipeline
//   ID_Stall     out  1   hazard stall to the decoder and IF/ID latch
//   ID_RsFwdSel  out  2   comparator Rs select (00 RF, 01 MEM, 10 WB)
//   ID_RtFwdSel  out  2   comparator Rt select
//   EX_RsFwdSel  out  2   ALU Rs select
//   EX_RtFwdSel  out  2   ALU Rt select
//   Stall_Count  out  16  saturating hazard stall cycle count
module hazard_unit (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  DP_Hazards,
    input  logic [4:0]  ID_Rs,
    input  logic [4:0]  ID_Rt,
    input  logic [4:0]  ID_WriteReg,
    input  logic        ID_RegWrite,
    input  logic        ID_MemRead,
    input  logic        Mem_Stall,
    output logic        ID_Stall,
    output logic [1:0]  ID_RsFwdSel,
    output logic [1:0]  ID_RtFwdSel,
    output logic [1:0]  EX_RsFwdSel,
    output logic [1:0]  EX_RtFwdSel,
    output logic [15:0] Stall_Count
);

    // Register 0 is hardwired to zero, so it never produces a hazard.
    function automatic logic reg_match(input logic       reg_write,
                                       input logic [4:0] write_reg,
                                       input logic [4:0] src);
        return reg_write && (write_reg == src) && (src != 5'd0);
    endfunction

    // Forwarding priority: MEM (younger, non-load) over WB over register file.
    function automatic logic [1:0] fwd_select(input logic want,
                                              input logic mem_hit,
                                              input logic mem_load,
                                              input logic wb_hit);
        if (!want)                   return 2'b00;
        else if (mem_hit && !mem_load) return 2'b01;
        else if (wb_hit)             return 2'b10;
        else                         return 2'b00;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

    logic want_rs_id, need_rs_id, want_rt_id, need_rt_id;
    logic want_rs_ex, need_rs_ex, want_rt_ex, need_rt_ex;

    assign {want_rs_id, need_rs_id, want_rt_id, need_rt_id,
            want_rs_ex, need_rs_ex, want_rt_ex, need_rt_ex} = DP_Hazards;

    // EX shadow stage
    logic [4:0] ex_write_reg;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic [4:0] ex_rs;
    logic [4:0] ex_rt;
    logic       ex_want_rs;
    logic       ex_want_rt;

    // MEM shadow stage
    logic [4:0] mem_write_reg;
    logic       mem_reg_write;
    logic       mem_mem_read;

    // WB shadow stage
    logic [4:0] wb_write_reg;
    logic       wb_reg_write;

    logic [15:0] stall_count;

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
    logic mem_hit_ex_rs, mem_hit_ex_rt, wb_hit_ex_rs, wb_hit_ex_rt;
    logic stall_rs, stall_rt, hazard_stall;

    // ---- Hazard detection against the instruction in ID ----
    always_comb begin
        ex_hit_rs  = reg_match(ex_reg_write,  ex_write_reg,  ID_Rs);
        ex_hit_rt  = reg_match(ex_reg_write,  ex_write_reg,  ID_Rt);
        mem_hit_rs = reg_match(mem_reg_write, mem_write_reg, ID_Rs);
        mem_hit_rt = reg_match(mem_reg_write, mem_write_reg, ID_Rt);
        wb_hit_rs  = reg_match(wb_reg_write,  wb_write_reg,  ID_Rs);
        wb_hit_rt  = reg_match(wb_reg_write,  wb_write_reg,  ID_Rt);

        stall_rs = (need_rs_id && ex_hit_rs)
                 || (need_rs_id && mem_hit_rs && mem_mem_read)
                 || (need_rs_ex && ex_hit_rs && ex_mem_read);
        stall_rt = (need_rt_id && ex_hit_rt)
                 || (need_rt_id && mem_hit_rt && mem_mem_read)
                 || (need_rt_ex && ex_hit_rt && ex_mem_read);

        // A memory stall already freezes everything; a hazard stall on top
        // of it would only double-count.
        hazard_stall = (stall_rs || stall_rt) && !Mem_Stall;
    end

    // ---- Forwarding for the registered EX operands ----
    always_comb begin
        mem_hit_ex_rs = reg_match(mem_reg_write, mem_write_reg, ex_rs);
        mem_hit_ex_rt = reg_match(mem_reg_write, mem_write_reg, ex_rt);
        wb_hit_ex_rs  = reg_match(wb_reg_write,  wb_write_reg,  ex_rs);
        wb_hit_ex_rt  = reg_match(wb_reg_write,  wb_write_reg,  ex_rt);
    end

    assign ID_Stall    = hazard_stall;
    assign ID_RsFwdSel = fwd_select(want_rs_id, mem_hit_rs, mem_mem_read, wb_hit_rs);
    assign ID_RtFwdSel = fwd_select(want_rt_id, mem_hit_rt, mem_mem_read, wb_hit_rt);
    assign EX_RsFwdSel = fwd_select(ex_want_rs, mem_hit_ex_rs, mem_mem_read, wb_hit_ex_rs);
    assign EX_RtFwdSel = fwd_select(ex_want_rt, mem_hit_ex_rt, mem_mem_read, wb_hit_ex_rt);
    assign Stall_Count = stall_count;

    // ---- Shadow pipeline advance ----
    always_ff @(posedge clock) begin
        if (reset) begin
            ex_write_reg  <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_rs         <= 5'd0;
            ex_rt         <= 5'd0;
            ex_want_rs    <= 1'b0;
            ex_want_rt    <= 1'b0;
            mem_write_reg <= 5'd0;
            mem_reg_write <= 1'b0;
            mem_mem_read  <= 1'b0;
            wb_write_reg  <= 5'd0;
            wb_reg_write  <= 1'b0;
        end else if (!Mem_Stall) begin
            if (hazard_stall) begin
                // Bubble into EX while the stalled instruction waits in ID.
                ex_write_reg <= 5'd0;
                ex_reg_write <= 1'b0;
                ex_mem_read  <= 1'b0;
                ex_rs        <= 5'd0;
                ex_rt        <= 5'd0;
                ex_want_rs   <= 1'b0;
                ex_want_rt   <= 1'b0;
            end else begin
                ex_write_reg <= ID_WriteReg;
                ex_reg_write <= ID_RegWrite;
                ex_mem_read  <= ID_MemRead;
                ex_rs        <= ID_Rs;
                ex_rt        <= ID_Rt;
                ex_want_rs   <= want_rs_ex;
                ex_want_rt   <= want_rt_ex;
            end
            mem_write_reg <= ex_write_reg;
            mem_reg_write <= ex_reg_write;
            mem_mem_read  <= ex_mem_read;
            wb_write_reg  <= mem_write_reg;
            wb_reg_write  <= mem_reg_write;
        end
    end

    // ---- Stall cycle counter ----
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_count <= 16'd0;
        end else if (hazard_stall) begin
            stall_count <= sat_inc(stall_count);
        end
    end

endmodule
